// File: rtl/hdmi_frame_reader_out.sv
// HDMI output timing generator and frame-buffer reader: places an RGB565 image window
// inside the active area, fills the remainder with border colour and emits RGB888.
module hdmi_frame_reader_out #(
   parameter int          H_ACTIVE   = 1280,
   parameter int          H_FP       = 110,
   parameter int          H_SYNC     = 40,
   parameter int          H_BP       = 220,
   parameter int          V_ACTIVE   = 720,
   parameter int          V_FP       = 5,
   parameter int          V_SYNC     = 5,
   parameter int          V_BP       = 20,
   parameter bit          SYNC_POL   = 1'b1,
   parameter logic [23:0] BORDER_RGB = 24'h000000
) (
   input  logic        pix_clk,
   input  logic        rst,
   input  logic [15:0] win_x,
   input  logic [15:0] win_y,
   input  logic [15:0] win_w,
   input  logic [15:0] win_h,
   input  logic        rd_empty,
   input  logic [15:0] rd_data,
   input  logic        underflow_clr,
   output logic        rd_req,
   output logic        frame_start,
   output logic        hs_out,
   output logic        vs_out,
   output logic        de_out,
   output logic [23:0] rgb_out,
   output logic        underflow
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
   localparam logic [15:0] HS_END   = 16'(H_SYNC);
   localparam logic [15:0] VS_END   = 16'(V_SYNC);
   localparam logic [15:0] HA_START = 16'(H_SYNC + H_BP);
   localparam logic [15:0] HA_END   = 16'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [15:0] VA_START = 16'(V_SYNC + V_BP);
   localparam logic [15:0] VA_END   = 16'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [16:0] H_LIM    = 17'(H_ACTIVE);
   localparam logic [16:0] V_LIM    = 17'(V_ACTIVE);

   logic [15:0] h_cnt;
   logic [15:0] v_cnt;

   // Frame-stable window: left/top edges plus clipped exclusive right/bottom edges.
   logic [15:0] x0;
   logic [15:0] y0;
   logic [16:0] x_end;
   logic [16:0] y_end;

   logic        hs_d;
   logic        vs_d;
   logic        de_d;
   logic        take_d;

   logic        frame_top;
   logic        h_act;
   logic        v_act;
   logic        active;
   logic [15:0] ax;
   logic [15:0] ay;
   logic        x_in;
   logic        y_in;
   logic        in_win;
   logic        starve;
   logic [16:0] x_sum;
   logic [16:0] y_sum;
   logic [16:0] x_clip;
   logic [16:0] y_clip;

   function automatic logic [23:0] rgb888(input logic [15:0] p);
      return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
   endfunction

   always_comb begin
      frame_top = (h_cnt == 16'd0) && (v_cnt == 16'd0);
      h_act     = (h_cnt >= HA_START) && (h_cnt < HA_END);
      v_act     = (v_cnt >= VA_START) && (v_cnt < VA_END);
      active    = h_act && v_act;
      ax        = h_cnt - HA_START;
      ay        = v_cnt - VA_START;
      x_in      = ({1'b0, ax} >= {1'b0, x0}) && ({1'b0, ax} < x_end);
      y_in      = ({1'b0, ay} >= {1'b0, y0}) && ({1'b0, ay} < y_end);
      in_win    = active && x_in && y_in;
      starve    = in_win && rd_empty;
      x_sum     = {1'b0, win_x} + {1'b0, win_w};
      y_sum     = {1'b0, win_y} + {1'b0, win_h};
      x_clip    = (x_sum > H_LIM) ? H_LIM : x_sum;
      y_clip    = (y_sum > V_LIM) ? V_LIM : y_sum;
   end

   assign rd_req      = in_win && !rd_empty && !rst;
   assign frame_start = frame_top && !rst;

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         h_cnt     <= 16'd0;
         v_cnt     <= 16'd0;
         x0        <= 16'd0;
         y0        <= 16'd0;
         x_end     <= 17'd0;
         y_end     <= 17'd0;
         hs_d      <= ~SYNC_POL;
         vs_d      <= ~SYNC_POL;
         de_d      <= 1'b0;
         take_d    <= 1'b0;
         hs_out    <= ~SYNC_POL;
         vs_out    <= ~SYNC_POL;
         de_out    <= 1'b0;
         rgb_out   <= 24'h000000;
         underflow <= 1'b0;
      end else begin
         if (h_cnt == H_LAST) begin
            h_cnt <= 16'd0;
            v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
         end else begin
            h_cnt <= h_cnt + 16'd1;
         end

         if (frame_top) begin
            x0    <= win_x;
            y0    <= win_y;
            x_end <= x_clip;
            y_end <= y_clip;
         end

         hs_d   <= (h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
         vs_d   <= (v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
         de_d   <= active;
         take_d <= rd_req;

         hs_out <= hs_d;
         vs_out <= vs_d;
         de_out <= de_d;
         // rd_data is only meaningful in the cycle after a read was issued.
         if (take_d) begin
            rgb_out <= rgb888(rd_data);
         end else if (de_d) begin
            rgb_out <= BORDER_RGB;
         end else begin
            rgb_out <= 24'h000000;
         end

         // A starved pixel in the same cycle as a clear keeps the flag set.
         if (starve) begin
            underflow <= 1'b1;
         end else if (underflow_clr) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_frame_reader_out.sv
// Self-checking bench for hdmi_frame_reader_out: table-driven window frames, corner-case
// sequences and randomized FIFO starvation, all against a position-based reference model.
module tb_hdmi_frame_reader_out;

   localparam bit          POL    = 1'b1;
   localparam logic [23:0] BORDER = 24'h102030;
   localparam int HT = 24, VT = 13, HA0 = 6, VA0 = 4, HACT = 16, VACT = 8, HSW = 3, VSW = 2;
   localparam int FRAME = HT * VT;

   logic        pix_clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] win_x = 16'd0, win_y = 16'd0, win_w = 16'd0, win_h = 16'd0;
   logic        rd_empty = 1'b0;
   logic [15:0] rd_data = 16'd0;
   logic        underflow_clr = 1'b0;
   logic        rd_req, frame_start, hs_out, vs_out, de_out, underflow;
   logic [23:0] rgb_out;

   always #5 pix_clk = ~pix_clk;

   hdmi_frame_reader_out #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(POL), .BORDER_RGB(BORDER)
   ) dut (
      .pix_clk(pix_clk), .rst(rst),
      .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
      .rd_empty(rd_empty), .rd_data(rd_data), .underflow_clr(underflow_clr),
      .rd_req(rd_req), .frame_start(frame_start),
      .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
      .rgb_out(rgb_out), .underflow(underflow)
   );

   typedef struct {
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] rgb;
   } orec_t;

   typedef struct {
      int x;
      int y;
      int w;
      int h;
      int reqs;
   } vec_t;

   int checks = 0, failures = 0;

   // reference model state
   int    mh, mv, sx, sy, sw, sh, m_idx, fifo_idx;
   bit    muf, req_prev;
   orec_t exp_now, exp_next, rst_rec;
   logic [15:0] fifo_mem [4096];

   // stimulus controls
   bit rand_empty = 1'b0, clr_at_force = 1'b0, cap_en = 1'b0;
   int force_h = -1, force_v = -1;

   // per-frame statistics
   int st_req, st_de, st_hs, st_vs, st_fs, st_first_de, st_cyc;
   bit prev_de;
   logic [23:0] cap [3];
   int cap_n = 0;
   logic [23:0] cap_force;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] expand(input logic [15:0] p);
      int r, g, b;
      r = int'(p[15:11]);
      g = int'(p[10:5]);
      b = int'(p[4:0]);
      return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
   endfunction

   function automatic bit m_active();
      return (mh >= HA0) && (mh < HA0 + HACT) && (mv >= VA0) && (mv < VA0 + VACT);
   endfunction

   function automatic bit m_in_win();
      int ax, ay;
      if (!m_active()) return 1'b0;
      ax = mh - HA0;
      ay = mv - VA0;
      return (ax >= sx) && (ax < sx + sw) && (ay >= sy) && (ay < sy + sh);
   endfunction

   // One pixel clock; entered and left just after a falling edge.
   task automatic step();
      orec_t rec;
      bit act, inw, xreq, at_force;
      if (req_prev) begin
         rd_data = fifo_mem[fifo_idx & 4095];
         fifo_idx++;
      end else begin
         rd_data = 16'($urandom);
      end
      if (rand_empty) begin
         rd_empty = ($urandom_range(0, 3) == 0);
         underflow_clr = ($urandom_range(0, 40) == 0);
      end
      at_force = (force_h >= 0) && (mh == force_h) && (mv == force_v);
      if (force_h >= 0) rd_empty = at_force;
      if (clr_at_force) underflow_clr = at_force;
      #1;
      act  = m_active();
      inw  = m_in_win();
      xreq = !rst && inw && !rd_empty;
      chk("rd_req", 32'(rd_req), 32'(xreq));
      chk("frame_start", 32'(frame_start), 32'(!rst && mh == 0 && mv == 0));
      chk("hs_out", 32'(hs_out), 32'(exp_now.hs));
      chk("vs_out", 32'(vs_out), 32'(exp_now.vs));
      chk("de_out", 32'(de_out), 32'(exp_now.de));
      chk("rgb_out", 32'(rgb_out), 32'(exp_now.rgb));
      chk("underflow", 32'(underflow), 32'(muf));
      if (rd_req) st_req++;
      if (de_out) st_de++;
      if (hs_out == POL) st_hs++;
      if (vs_out == POL) st_vs++;
      if (frame_start) st_fs++;
      if (de_out && !prev_de && st_first_de < 0) st_first_de = st_cyc;
      prev_de = de_out;
      if (cap_en && de_out && cap_n < 3) begin
         cap[cap_n] = rgb_out;
         cap_n++;
      end
      if (force_h >= 0 && mh == force_h + 2 && mv == force_v) cap_force = rgb_out;
      st_cyc++;
      req_prev = rd_req;
      rec.hs = (mh < HSW) ? POL : !POL;
      rec.vs = (mv < VSW) ? POL : !POL;
      rec.de = act;
      if (xreq) begin
         rec.rgb = expand(fifo_mem[m_idx & 4095]);
         m_idx++;
      end else begin
         rec.rgb = act ? BORDER : 24'h000000;
      end
      @(posedge pix_clk);
      if (rst) begin
         mh = 0; mv = 0; sx = 0; sy = 0; sw = 0; sh = 0;
         muf = 1'b0;
         exp_now = rst_rec;
         exp_next = rst_rec;
      end else begin
         if (inw && rd_empty) muf = 1'b1;
         else if (underflow_clr) muf = 1'b0;
         if (mh == 0 && mv == 0) begin
            sx = int'(win_x); sy = int'(win_y); sw = int'(win_w); sh = int'(win_h);
         end
         exp_now = exp_next;
         exp_next = rec;
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end
      @(negedge pix_clk);
   endtask

   task automatic run_frame(input int chg_at, input int new_x);
      st_req = 0; st_de = 0; st_hs = 0; st_vs = 0; st_fs = 0; st_cyc = 0;
      st_first_de = -1;
      prev_de = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
         if (c == chg_at) win_x = 16'(new_x);
         step();
      end
   endtask

   task automatic sync_frame();
      for (int c = 0; c < FRAME && !(mh == 0 && mv == 0); c++) step();
   endtask

   task automatic set_win(input int x, input int y, input int w, input int h);
      win_x = 16'(x); win_y = 16'(y); win_w = 16'(w); win_h = 16'(h);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 4096; k++) begin
         if (k == 0) fifo_mem[k] = 16'hF800;
         else if (k == 1) fifo_mem[k] = 16'h07E0;
         else if (k == 2) fifo_mem[k] = 16'h001F;
         else if (k < 1500) fifo_mem[k] = 16'(k);
         else fifo_mem[k] = 16'($urandom);
      end
      vecs[0] = '{x: 0,  y: 0, w: 16, h: 8,  reqs: 128};
      vecs[1] = '{x: 4,  y: 2, w: 8,  h: 4,  reqs: 32};
      vecs[2] = '{x: 12, y: 6, w: 10, h: 10, reqs: 8};
      vecs[3] = '{x: 3,  y: 1, w: 0,  h: 5,  reqs: 0};
      vecs[4] = '{x: 2,  y: 2, w: 5,  h: 0,  reqs: 0};
      vecs[5] = '{x: 10, y: 4, w: 16, h: 8,  reqs: 24};
      vecs[6] = '{x: 20, y: 0, w: 4,  h: 4,  reqs: 0};

      rst_rec.hs = !POL; rst_rec.vs = !POL; rst_rec.de = 1'b0; rst_rec.rgb = 24'h000000;
      rst = 1'b1;
      repeat (3) @(posedge pix_clk);
      @(negedge pix_clk);
      mh = 0; mv = 0; sx = 0; sy = 0; sw = 0; sh = 0;
      muf = 1'b0; m_idx = 0; fifo_idx = 0; req_prev = 1'b0;
      exp_now = rst_rec; exp_next = rst_rec;
      step();
      step();
      rst = 1'b0;

      // table of windows with expected reads per frame
      for (int i = 0; i < 7; i++) begin
         set_win(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h);
         for (int f = 0; f < ((i == 0) ? 3 : 1); f++) begin
            cap_en = (i == 0 && f == 0);
            run_frame(-1, 0);
            chk($sformatf("reads_v%0d", i), 32'(st_req), 32'(vecs[i].reqs));
            if (i == 0) begin
               chk("de_per_frame", 32'(st_de), 32'd128);
               chk("hs_cycles", 32'(st_hs), 32'(VT * HSW));
               chk("vs_cycles", 32'(st_vs), 32'(VSW * HT));
               chk("fs_per_frame", 32'(st_fs), 32'd1);
               chk("first_de_idx", 32'(st_first_de), 32'(VA0 * HT + HA0 + 2));
            end
         end
      end
      cap_en = 1'b0;
      chk("rgb_red", 32'(cap[0]), 32'h00FF0000);
      chk("rgb_green", 32'(cap[1]), 32'h0000FF00);
      chk("rgb_blue", 32'(cap[2]), 32'h000000FF);

      // starved pixel (5,3) inside window (4,2,8,4)
      set_win(4, 2, 8, 4);
      force_h = HA0 + 4 + 5;
      force_v = VA0 + 2 + 3;
      run_frame(-1, 0);
      chk("reads_starved", 32'(st_req), 32'd31);
      chk("starved_pixel", 32'(cap_force), 32'(BORDER));
      chk("uf_sticky", 32'(underflow), 32'd1);
      force_h = -1;
      rd_empty = 1'b0;
      underflow_clr = 1'b1;
      step();
      underflow_clr = 1'b0;
      step();
      chk("uf_clr", 32'(underflow), 32'd0);
      sync_frame();
      // clear coinciding with a new starvation: the set must win
      force_h = HA0 + 4;
      force_v = VA0 + 2;
      clr_at_force = 1'b1;
      run_frame(-1, 0);
      clr_at_force = 1'b0;
      underflow_clr = 1'b0;
      force_h = -1;
      rd_empty = 1'b0;
      chk("uf_set_wins", 32'(underflow), 32'd1);
      underflow_clr = 1'b1;
      step();
      underflow_clr = 1'b0;
      sync_frame();

      // mid-frame window change applies only from the next frame
      set_win(0, 0, 16, 8);
      run_frame(150, 8);
      chk("reads_old_win", 32'(st_req), 32'd128);
      run_frame(-1, 0);
      chk("reads_new_win", 32'(st_req), 32'd64);

      // one-cycle reset in the middle of an active line
      for (int c = 0; c < FRAME && !(mh == 10 && mv == 5); c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst_de", 32'(de_out), 32'd0);
      chk("rst_rd_req", 32'(rd_req), 32'd0);
      chk("rst_hs", 32'(hs_out), 32'(!POL));
      chk("rst_vs", 32'(vs_out), 32'(!POL));
      chk("rst_rgb", 32'(rgb_out), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd1);
      run_frame(-1, 0);
      chk("reads_after_rst", 32'(st_req), 32'd64);

      // randomized windows and FIFO starvation
      rand_empty = 1'b1;
      for (int f = 0; f < 6; f++) begin
         set_win($urandom_range(0, 18), $urandom_range(0, 9),
                 $urandom_range(0, 18), $urandom_range(0, 9));
         run_frame(-1, 0);
      end
      rand_empty = 1'b0;
      rd_empty = 1'b0;
      underflow_clr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
